// File: rtl/halt_pkg.sv
// Shared types and constants for the end-of-run halt monitor.
package halt_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } halt_state_t;

  typedef enum logic [1:0] {
    NONE       = 2'd0,
    LOOP       = 2'd1,
    BREAKPOINT = 2'd2,
    EXCEPTION  = 2'd3
  } halt_reason_t;

  localparam int MCAUSE_BREAKPOINT_BIT = 3;

endpackage

// File: rtl/loop_detector.sv
// Detects LOOP_COUNT consecutive retirements at one address; emits a registered
// one-cycle loop_o pulse together with the looping address.
module loop_detector
  import halt_pkg::*;
#(
  parameter int unsigned LOOP_COUNT = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        retire_valid_i,
  input  logic [31:0] retire_addr_i,
  output logic        loop_o,
  output logic [31:0] loop_addr_o
);

  localparam int unsigned CW = $clog2(LOOP_COUNT + 1);

  logic [31:0]   last_addr;
  logic          last_valid;
  logic [CW-1:0] loop_cnt;
  logic          same_addr;

  assign same_addr = last_valid && (retire_addr_i == last_addr);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_addr   <= '0;
      last_valid  <= 1'b0;
      loop_cnt    <= '0;
      loop_o      <= 1'b0;
      loop_addr_o <= '0;
    end else begin
      loop_o <= 1'b0;
      if (retire_valid_i) begin
        if (same_addr) begin
          if (loop_cnt != CW'(LOOP_COUNT)) loop_cnt <= loop_cnt + CW'(1);
          // Fires only on the increment that reaches LOOP_COUNT, not while saturated.
          if (loop_cnt == CW'(LOOP_COUNT - 1)) begin
            loop_o      <= 1'b1;
            loop_addr_o <= retire_addr_i;
          end
        end else begin
          last_addr  <= retire_addr_i;
          last_valid <= 1'b1;
          loop_cnt   <= CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/halt_monitor.sv
// End-of-run detector: loop/breakpoint/exception -> DRAIN -> sticky HALTED.
// Define HALT_MONITOR_STATS_EN to build the 64-bit cycle and instret counters.
module halt_monitor
  import halt_pkg::*;
#(
  parameter int unsigned LOOP_COUNT   = 4,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        retire_valid_i,
  input  logic [31:0] retire_addr_i,
  input  logic        trap_valid_i,
  input  logic [31:0] trap_mcause_i,
  input  logic [31:0] trap_addr_i,
  output logic        halt_req_o,
  output logic        halted_o,
  output logic [1:0]  halt_reason_o,
  output logic [31:0] halt_addr_o,
  output logic [31:0] halt_mcause_o,
  output logic [63:0] cycle_count_o,
  output logic [63:0] instret_count_o
);

  localparam int unsigned DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  halt_state_t    state;
  halt_reason_t   reason_q;
  logic [DCW-1:0] drain_cnt;

  logic        loop_pulse;
  logic [31:0] loop_addr;

  logic        trap_q;
  logic [31:0] trap_mcause_q;
  logic [31:0] trap_addr_q;

  logic         trig;
  halt_reason_t trig_reason;
  logic [31:0]  trig_addr;
  logic [31:0]  trig_mcause;

  loop_detector #(
    .LOOP_COUNT(LOOP_COUNT)
  ) u_loop_detector (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .retire_valid_i (retire_valid_i),
    .retire_addr_i  (retire_addr_i),
    .loop_o         (loop_pulse),
    .loop_addr_o    (loop_addr)
  );

  // Traps are registered so they line up with the registered loop pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      trap_q        <= 1'b0;
      trap_mcause_q <= '0;
      trap_addr_q   <= '0;
    end else begin
      trap_q        <= trap_valid_i;
      trap_mcause_q <= trap_mcause_i;
      trap_addr_q   <= trap_addr_i;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    trig        = trap_q || loop_pulse;
    trig_reason = NONE;
    trig_addr   = '0;
    trig_mcause = '0;
    if (trap_q) begin
      trig_reason = trap_mcause_q[MCAUSE_BREAKPOINT_BIT] ? BREAKPOINT : EXCEPTION;
      trig_addr   = trap_addr_q;
      trig_mcause = trap_mcause_q;
    end else if (loop_pulse) begin
      trig_reason = LOOP;
      trig_addr   = loop_addr;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= RUN;
      drain_cnt     <= '0;
      reason_q      <= NONE;
      halt_addr_o   <= '0;
      halt_mcause_o <= '0;
      halt_req_o    <= 1'b0;
      halted_o      <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (trig) begin
            reason_q      <= trig_reason;
            halt_addr_o   <= trig_addr;
            halt_mcause_o <= trig_mcause;
            halt_req_o    <= 1'b1;
            if (DRAIN_CYCLES == 0) begin
              state    <= HALTED;
              halted_o <= 1'b1;
            end else begin
              state     <= DRAIN;
              drain_cnt <= DCW'(DRAIN_CYCLES);
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DCW'(1)) begin
            state    <= HALTED;
            halted_o <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign halt_reason_o = reason_q;

`ifdef HALT_MONITOR_STATS_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cycle_count_o   <= '0;
      instret_count_o <= '0;
    end else if (state != HALTED) begin
      cycle_count_o <= cycle_count_o + 64'd1;
      if (retire_valid_i) instret_count_o <= instret_count_o + 64'd1;
    end
  end
`else
  assign cycle_count_o   = '0;
  assign instret_count_o = '0;
`endif

endmodule

// File: tb/tb_halt_monitor.sv
// Self-checking bench for halt_monitor: two instances (DRAIN_CYCLES 4 and 0)
// share stimulus and are compared against an event-level reference model.
module tb_halt_monitor;

  localparam int LC = 4;
  localparam int D_CFG [2] = '{4, 0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        retire_valid = 1'b0;
  logic [31:0] retire_addr = '0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_mcause = '0;
  logic [31:0] trap_addr = '0;

  logic        halt_req_a, halted_a, halt_req_b, halted_b;
  logic [1:0]  reason_a, reason_b;
  logic [31:0] addr_a, addr_b, mcause_a, mcause_b;
  logic [63:0] cyc_a, cyc_b, inst_a, inst_b;

  halt_monitor #(.LOOP_COUNT(LC), .DRAIN_CYCLES(4)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n),
    .retire_valid_i(retire_valid), .retire_addr_i(retire_addr),
    .trap_valid_i(trap_valid), .trap_mcause_i(trap_mcause), .trap_addr_i(trap_addr),
    .halt_req_o(halt_req_a), .halted_o(halted_a), .halt_reason_o(reason_a),
    .halt_addr_o(addr_a), .halt_mcause_o(mcause_a),
    .cycle_count_o(cyc_a), .instret_count_o(inst_a)
  );

  halt_monitor #(.LOOP_COUNT(LC), .DRAIN_CYCLES(0)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n),
    .retire_valid_i(retire_valid), .retire_addr_i(retire_addr),
    .trap_valid_i(trap_valid), .trap_mcause_i(trap_mcause), .trap_addr_i(trap_addr),
    .halt_req_o(halt_req_b), .halted_o(halted_b), .halt_reason_o(reason_b),
    .halt_addr_o(addr_b), .halt_mcause_o(mcause_b),
    .cycle_count_o(cyc_b), .instret_count_o(inst_b)
  );

  always #5 clk = ~clk;

  logic [3:0]   act_status;
  logic [131:0] act_fields;
  logic [255:0] act_counters;
  assign act_status   = {halt_req_a, halted_a, halt_req_b, halted_b};
  assign act_fields   = {reason_a, addr_a, mcause_a, reason_b, addr_b, mcause_b};
  assign act_counters = {cyc_a, inst_a, cyc_b, inst_b};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the first trigger since reset wins; everything else is
  // derived from the edge index at which it was sampled.
  int              edge_n, trig_edge, run_len;
  logic            have_addr;
  logic [31:0]     run_addr;
  logic [1:0]      m_reason;
  logic [31:0]     m_addr, m_mcause;
  longint unsigned m_cyc [2];
  longint unsigned m_inst [2];

  task automatic model_clear();
    edge_n = 0; trig_edge = -1; run_len = 0; have_addr = 1'b0; run_addr = '0;
    m_reason = '0; m_addr = '0; m_mcause = '0;
    for (int k = 0; k < 2; k++) begin m_cyc[k] = 0; m_inst[k] = 0; end
  endtask

  task automatic model_edge();
    logic loop_fire;
    edge_n++;
    loop_fire = 1'b0;
    if (retire_valid) begin
      if (have_addr && retire_addr == run_addr) run_len++;
      else begin run_addr = retire_addr; have_addr = 1'b1; run_len = 1; end
      loop_fire = (run_len == LC);
    end
    for (int k = 0; k < 2; k++)
      if (trig_edge < 0 || edge_n <= trig_edge + 1 + D_CFG[k]) begin
        m_cyc[k]++;
        if (retire_valid) m_inst[k]++;
      end
    if (trig_edge < 0 && (trap_valid || loop_fire)) begin
      trig_edge = edge_n;
      if (trap_valid) begin
        m_reason = trap_mcause[3] ? 2'd2 : 2'd3;
        m_addr   = trap_addr;
        m_mcause = trap_mcause;
      end else begin
        m_reason = 2'd1;
        m_addr   = retire_addr;
        m_mcause = '0;
      end
    end
  endtask

  function automatic logic exp_req();
    return trig_edge >= 0 && edge_n >= trig_edge + 1;
  endfunction

  function automatic logic exp_halted(int k);
    return trig_edge >= 0 && edge_n >= trig_edge + 1 + D_CFG[k];
  endfunction

  function automatic logic [3:0] exp_status();
    return {exp_req(), exp_halted(0), exp_req(), exp_halted(1)};
  endfunction

  function automatic logic [131:0] exp_fields();
    if (exp_req()) return {m_reason, m_addr, m_mcause, m_reason, m_addr, m_mcause};
    return '0;
  endfunction

  function automatic logic [255:0] exp_counters();
`ifdef HALT_MONITOR_STATS_EN
    return {m_cyc[0], m_inst[0], m_cyc[1], m_inst[1]};
`else
    return '0;
`endif
  endfunction

  task automatic drive(input logic rv, input logic [31:0] ra,
                       input logic tv, input logic [31:0] tm, input logic [31:0] ta);
    retire_valid = rv; retire_addr = ra;
    trap_valid = tv; trap_mcause = tm; trap_addr = ta;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    model_clear();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({act_status, act_fields, act_counters} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got status=%b fields=%h counters=%h, want all zero",
               act_status, act_fields, act_counters);
    end
  endtask

  // Four retires at 0x8000_0100, then idle until instance A halts.
  task automatic run_loop_sequence(input string tag);
    for (int i = 0; i < LC; i++) begin
      drive(1'b1, 32'h8000_0100, 1'b0, '0, '0);
      step();
      n_checks++;
      if (act_status !== exp_status()) begin
        n_fail++;
        $display("FAIL %s_retire%0d_status: got %b want %b", tag, i, act_status, exp_status());
      end
    end
    drive(1'b0, '0, 1'b0, '0, '0);
    step();
    n_checks++;
    if (act_status !== 4'b1011 || act_fields !== {2'd1, 32'h8000_0100, 32'h0, 2'd1, 32'h8000_0100, 32'h0}) begin
      n_fail++;
      $display("FAIL %s_req_latency: got status=%b fields=%h, want status=1011 reason=1 addr=80000100 mcause=0",
               tag, act_status, act_fields);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (halted_a !== (i == 3)) begin
        n_fail++;
        $display("FAIL %s_halted_edge+%0d: got %b want %b", tag, i + 2, halted_a, (i == 3));
      end
    end
    n_checks++;
    if (act_counters !== exp_counters()) begin
      n_fail++;
      $display("FAIL %s_counters: got %h want %h", tag, act_counters, exp_counters());
    end
  endtask

  task automatic test_loop_halt();
    apply_reset();
    run_loop_sequence("loop");
  endtask

  task automatic test_no_loop_restart();
    logic [31:0] seq [6] = '{32'h100, 32'h100, 32'h104, 32'h100, 32'h100, 32'h100};
    apply_reset();
    foreach (seq[i]) begin
      drive(1'b1, seq[i], 1'b0, '0, '0);
      step();
    end
    drive(1'b0, '0, 1'b0, '0, '0);
    repeat (4) step();
    n_checks++;
    if (act_status !== 4'b0000 || exp_status() !== 4'b0000) begin
      n_fail++;
      $display("FAIL no_loop_status: got %b model %b want 0000", act_status, exp_status());
    end
    n_checks++;
    if (act_counters !== exp_counters()) begin
      n_fail++;
      $display("FAIL no_loop_counters: got %h want %h", act_counters, exp_counters());
    end
  endtask

  task automatic test_trap_priority();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h8000_0300, 1'b0, '0, '0);
      step();
    end
    drive(1'b1, 32'h8000_0300, 1'b1, 32'h0000_0008, 32'h8000_0200);
    step();
    drive(1'b0, '0, 1'b0, '0, '0);
    step();
    n_checks++;
    if (act_fields !== {2'd2, 32'h8000_0200, 32'h8, 2'd2, 32'h8000_0200, 32'h8}) begin
      n_fail++;
      $display("FAIL trap_priority_fields: got %h want reason=2 addr=80000200 mcause=8", act_fields);
    end
    n_checks++;
    if (act_status !== exp_status()) begin
      n_fail++;
      $display("FAIL trap_priority_status: got %b want %b", act_status, exp_status());
    end
  endtask

  task automatic test_drain_ignore();
    apply_reset();
    drive(1'b1, 32'h40, 1'b0, '0, '0);
    step();
    drive(1'b0, '0, 1'b1, 32'h0000_0004, 32'h8000_0400);
    step();
    drive(1'b1, 32'h44, 1'b1, 32'h0000_0008, 32'h8000_0500);
    step();
    n_checks++;
    if ({halt_req_b, halted_b} !== 2'b11 || halt_req_a !== 1'b1 || halted_a !== 1'b0) begin
      n_fail++;
      $display("FAIL drain0_direct_halt: got status=%b want 1011", act_status);
    end
    repeat (3) step();
    drive(1'b0, '0, 1'b0, '0, '0);
    n_checks++;
    if (act_fields !== {2'd3, 32'h8000_0400, 32'h4, 2'd3, 32'h8000_0400, 32'h4}) begin
      n_fail++;
      $display("FAIL drain_ignore_fields: got %h want reason=3 addr=80000400 mcause=4", act_fields);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, '0, '0);
      step();
    end
    n_checks++;
    if (act_counters !== exp_counters()) begin
      n_fail++;
      $display("FAIL halted_counters_frozen: got %h want %h", act_counters, exp_counters());
    end
    n_checks++;
    if (act_status !== 4'b1111) begin
      n_fail++;
      $display("FAIL halted_sticky: got %b want 1111", act_status);
    end
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    for (int i = 0; i < LC; i++) begin
      drive(1'b1, 32'h8000_0100, 1'b0, '0, '0);
      step();
    end
    drive(1'b0, '0, 1'b0, '0, '0);
    repeat (2) step();
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({act_status, act_fields, act_counters} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_drain_outputs: got status=%b fields=%h counters=%h, want all zero",
               act_status, act_fields, act_counters);
    end
    repeat (2) @(negedge clk);
    model_clear();
    rst_n = 1'b1;
    run_loop_sequence("rerun");
  endtask

  task automatic test_random();
    logic [31:0] mc;
    for (int run = 0; run < 8; run++) begin
      apply_reset();
      for (int c = 0; c < 40; c++) begin
        mc = 32'd1 << $urandom_range(0, 11);
        if ($urandom_range(0, 1) == 1) mc = mc | (32'd1 << $urandom_range(0, 11));
        drive($urandom_range(0, 3) != 0,
              ($urandom_range(0, 3) == 0) ? 32'h104 : 32'h100,
              $urandom_range(0, 29) == 0, mc, $urandom & 32'hFFFF_FFFC);
        step();
        n_checks++;
        if (act_status !== exp_status()) begin
          n_fail++;
          $display("FAIL rand%0d_cyc%0d_status: got %b want %b", run, c, act_status, exp_status());
        end
      end
      n_checks++;
      if (act_fields !== exp_fields()) begin
        n_fail++;
        $display("FAIL rand%0d_fields: got %h want %h", run, act_fields, exp_fields());
      end
      n_checks++;
      if (act_counters !== exp_counters()) begin
        n_fail++;
        $display("FAIL rand%0d_counters: got %h want %h", run, act_counters, exp_counters());
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_loop_halt();
    test_no_loop_restart();
    test_trap_priority();
    test_drain_ignore();
    test_reset_mid_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/halt_monitor.md
# halt_monitor

Pipeline-side end-of-run detector for the pipelined RISC-V core. It sits between the retire/trap stage of `risc_p` and the simulation top. It watches retired instructions and trap reports and decides when execution has ended: a looping instruction, a breakpoint or another exception. It then drains for a fixed number of cycles and presents a sticky halted state with the halt reason, PC, mcause and run statistics for the top to report or dump.

## Interface
- `LOOP_COUNT`, default 4: consecutive retirements at the same address that declare a loop (≥2).
- `DRAIN_CYCLES`, default 4: cycles spent in DRAIN before HALTED (0 allowed).
- `clk_i` input 1: the single clock.
- `rst_n_i` input 1: reset, asynchronous and active-low.
- `retire_valid_i` input 1: one instruction retired this cycle.
- `retire_addr_i` input 32: address of the retired instruction.
- `trap_valid_i` input 1: the pipeline took a trap this cycle.
- `trap_mcause_i` input 32: one-hot mcause bits (bit 3 = breakpoint).
- `trap_addr_i` input 32: faulting instruction address.
- `halt_req_o` output 1: stop fetch/issue; high in DRAIN and HALTED.
- `halted_o` output 1: high in HALTED.
- `halt_reason_o` output 2: 0 NONE, 1 LOOP, 2 BREAKPOINT, 3 EXCEPTION.
- `halt_addr_o` output 32: latched PC of the halt cause.
- `halt_mcause_o` output 32: latched mcause bits; 0 for LOOP.
- `cycle_count_o` output 64: cycle counter.
- `instret_count_o` output 64: retired-instruction counter.

## Operation
- States are RUN, DRAIN and HALTED. Reset enters RUN. HALTED is left only by reset.
- Loop detector:
  - Holds `last_addr`, `last_valid` and a saturating `loop_cnt`.
  - On a retire with `last_valid` set and `retire_addr_i == last_addr`, `loop_cnt` increments, saturating at LOOP_COUNT.
  - On any other retire, `last_addr` takes the new address, `last_valid` sets and `loop_cnt` becomes 1.
  - Cycles without a retire leave all three unchanged.
  - The loop trigger fires when the increment makes `loop_cnt == LOOP_COUNT`.
- Triggers are evaluated only in RUN:
  - A trap with mcause bit 3 set gives BREAKPOINT.
  - Any other trap gives EXCEPTION.
  - A loop trigger gives LOOP.
  - Trap beats loop in the same cycle. BREAKPOINT beats EXCEPTION when several mcause bits are set.
- On a trigger, the block latches the reason, address (trap_addr_i or retire_addr_i) and mcause, loads `drain_cnt = DRAIN_CYCLES`, and enters DRAIN. With DRAIN_CYCLES = 0 it goes directly to HALTED.
- In DRAIN, `drain_cnt` decrements each cycle; when it reaches 1 the next state is HALTED.
- Triggers arriving in DRAIN or HALTED are ignored. The latched fields never change until reset.
- Reset values: every output is 0; state RUN; all counters 0; `last_valid` 0.
- Reset asserted mid-DRAIN or in HALTED returns the block to RUN on the next clock after release.

## Timing
- Trigger sampled at edge N: `halt_req_o` is high after edge N+1 (registered, one-cycle latency).
- `halted_o` rises after edge N+1+DRAIN_CYCLES and stays high.
- `halt_reason_o`, `halt_addr_o` and `halt_mcause_o` are valid from the same edge that raises `halt_req_o`.
- `cycle_count_o` increments every cycle while not HALTED.
- `instret_count_o` increments on `retire_valid_i` in RUN and DRAIN, so instructions retiring during the drain are counted.
- Both 64-bit counters wrap modulo 2^64 and freeze in HALTED.

## Configuration
- `HALT_MONITOR_STATS_EN` defined: both 64-bit counters are built.
- Undefined: no counter flops; `cycle_count_o` and `instret_count_o` are tied to 0. Halt behaviour is identical either way.

## Structure
- A shared package `halt_pkg` holds:
  - the `halt_state_t` enum (RUN, DRAIN, HALTED);
  - the `halt_reason_t` enum (NONE, LOOP, BREAKPOINT, EXCEPTION);
  - the constant `MCAUSE_BREAKPOINT_BIT = 3`.
- One sub-module, `loop_detector`, implements the last-address compare and saturating count and outputs a one-cycle `loop_o` pulse.

## Test plan
- Retire 0x8000_0100 four times back-to-back (LOOP_COUNT=4, DRAIN_CYCLES=4) -> `halt_req_o` after the 4th retire edge +1; reason 1; addr 0x8000_0100; mcause 0; `halted_o` 4 cycles later.
- Retire 0x100, 0x100, 0x104, 0x100, 0x100, 0x100 -> no halt (count restarts at each address change).
- Trap with mcause 0x0000_0008 at addr 0x8000_0200 in the same cycle as the 4th loop retire -> reason 2, addr 0x8000_0200, mcause 0x8.
- Trap mcause 0x0000_0004, then trap mcause 0x8 during DRAIN -> reason stays 3, mcause stays 0x4.
- DRAIN_CYCLES=0 with an exception at edge N -> `halt_req_o` and `halted_o` both high after edge N+1. With STATS_EN, counters hold their values over 10 more cycles.
- `rst_n_i` pulled low mid-DRAIN -> all outputs 0 immediately. After release, the same 4-retire loop halts again with identical latency.
